// File: rtl/io_bridge_fta_split_if.sv
// Bus bundle for the wide-to-narrow split bridge: CPU-side request/response
// plus the shared device-side beat port and per-channel device responses.
interface io_bridge_fta_split_if #(
   parameter int SW       = 128,
   parameter int MW       = 64,
   parameter int CHANNELS = 4,
   parameter int ADRW     = 32
);
   logic                   s_cyc_i;
   logic                   s_we_i;
   logic [SW/8-1:0]        s_sel_i;
   logic [ADRW-1:0]        s_adr_i;
   logic [SW-1:0]          s_dat_i;
   logic [7:0]             s_tid_i;
   logic                   s_stall_o;
   logic                   s_ack_o;
   logic                   s_err_o;
   logic [7:0]             s_tid_o;
   logic [SW-1:0]          s_dat_o;

   logic                   m_cyc_o;
   logic                   m_stb_o;
   logic                   m_we_o;
   logic [MW/8-1:0]        m_sel_o;
   logic [ADRW-1:0]        m_adr_o;
   logic [MW-1:0]          m_dat_o;
   logic [7:0]             m_tid_o;

   logic [CHANNELS-1:0]    ch_ack_i;
   logic [CHANNELS-1:0]    ch_err_i;
   logic [CHANNELS*8-1:0]  ch_tid_i;
   logic [CHANNELS*MW-1:0] ch_dat_i;

   modport slave (
      input  s_cyc_i, s_we_i, s_sel_i, s_adr_i, s_dat_i, s_tid_i,
      input  ch_ack_i, ch_err_i, ch_tid_i, ch_dat_i,
      output s_stall_o, s_ack_o, s_err_o, s_tid_o, s_dat_o,
      output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o, m_tid_o
   );

   modport master (
      output s_cyc_i, s_we_i, s_sel_i, s_adr_i, s_dat_i, s_tid_i,
      output ch_ack_i, ch_err_i, ch_tid_i, ch_dat_i,
      input  s_stall_o, s_ack_o, s_err_o, s_tid_o, s_dat_o,
      input  m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o, m_tid_o
   );
endinterface

// File: rtl/io_bridge_fta_split.sv
// Wide-to-narrow I/O bridge: splits one CPU request into narrow beats,
// merges read data back, with per-beat timeout and error termination.
module io_bridge_fta_split #(
   parameter int SW       = 128,
   parameter int MW       = 64,
   parameter int CHANNELS = 4,
   parameter int ADRW     = 32,
   parameter int TIMEOUT  = 1023
) (
   input logic                 clk_i,
   input logic                 rst_i,
   io_bridge_fta_split_if.slave bus
);
   localparam int R  = SW / MW;
   localparam int SB = $clog2(SW / 8);
   localparam int MB = $clog2(MW / 8);
   localparam int GW = (R > 1) ? $clog2(R) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t          state;
   logic [ADRW-1:0] adr_q;
   logic            we_q;
   logic [SW/8-1:0] sel_q;
   logic [SW-1:0]   dat_q;
   logic [7:0]      tid_q;
   logic [R-1:0]    mask_q;
   logic [GW-1:0]   g_q;
   logic [SW-1:0]   cap_q;
   logic [9:0]      cnt_q;

   logic            stall_r, ack_r, err_r;
   logic [7:0]      s_tid_r;
   logic [SW-1:0]   s_dat_r;
   logic            cyc_r, stb_r, we_r;
   logic [MW/8-1:0] sel_r;
   logic [ADRW-1:0] adr_r;
   logic [MW-1:0]   dat_r;
   logic [7:0]      tid_r;

   logic [R-1:0]    acc_mask, nmask;
   logic [GW-1:0]   acc_g, ng;
   logic            hit, hit_err, timeout;
   logic [MW-1:0]   hit_dat;
   logic [SW-1:0]   cap_nxt;

   function automatic logic [R-1:0] group_mask(input logic [SW/8-1:0] sel);
      logic [R-1:0] m;
      m = '0;
      for (int g = 0; g < R; g++)
         m[g] = |sel[g*(MW/8) +: MW/8];
      return m;
   endfunction

   function automatic logic [GW-1:0] lowest(input logic [R-1:0] m);
      logic [GW-1:0] r;
      r = '0;
      for (int g = R - 1; g >= 0; g--)
         if (m[g]) r = GW'(g);
      return r;
   endfunction

   // Lane group index replaces the low address bits above the beat offset.
   function automatic logic [ADRW-1:0] beat_adr(input logic [ADRW-1:0] a,
                                                input logic [GW-1:0] g);
      logic [ADRW-1:0] r;
      r = a;
      r[SB-1:0] = '0;
      return r | (ADRW'(g) << MB);
   endfunction

   always_comb begin
      acc_mask = group_mask(bus.s_sel_i);
      acc_g    = lowest(acc_mask);
      hit      = 1'b0;
      hit_err  = 1'b0;
      hit_dat  = '0;
      // Downward scan so the lowest matching channel is the final winner.
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         if ((bus.ch_ack_i[c] | bus.ch_err_i[c]) &&
             bus.ch_tid_i[c*8 +: 8] == tid_q) begin
            hit     = 1'b1;
            hit_err = bus.ch_err_i[c];
            hit_dat = bus.ch_dat_i[c*MW +: MW];
         end
      end
      cap_nxt = cap_q;
      if (!we_q) cap_nxt[g_q*MW +: MW] = hit_dat;
      nmask = mask_q;
      nmask[g_q] = 1'b0;
      ng = lowest(nmask);
      timeout = (cnt_q == 10'(TIMEOUT - 1));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         adr_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         dat_q   <= '0;
         tid_q   <= '0;
         mask_q  <= '0;
         g_q     <= '0;
         cap_q   <= '0;
         cnt_q   <= '0;
         stall_r <= 1'b0;
         ack_r   <= 1'b0;
         err_r   <= 1'b0;
         s_tid_r <= '0;
         s_dat_r <= '0;
         cyc_r   <= 1'b0;
         stb_r   <= 1'b0;
         we_r    <= 1'b0;
         sel_r   <= '0;
         adr_r   <= '1;
         dat_r   <= '0;
         tid_r   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.s_cyc_i) begin
                  adr_q   <= bus.s_adr_i;
                  we_q    <= bus.s_we_i;
                  sel_q   <= bus.s_sel_i;
                  dat_q   <= bus.s_dat_i;
                  tid_q   <= bus.s_tid_i;
                  mask_q  <= acc_mask;
                  g_q     <= acc_g;
                  cap_q   <= '0;
                  stall_r <= 1'b1;
                  we_r    <= bus.s_we_i;
                  tid_r   <= bus.s_tid_i;
                  if (acc_mask == '0) begin
                     state   <= DONE;
                     ack_r   <= 1'b1;
                     s_tid_r <= bus.s_tid_i;
                     s_dat_r <= '0;
                  end else begin
                     state <= ISSUE;
                     cyc_r <= 1'b1;
                     stb_r <= 1'b1;
                     adr_r <= beat_adr(bus.s_adr_i, acc_g);
                     sel_r <= bus.s_sel_i[acc_g*(MW/8) +: MW/8];
                     dat_r <= bus.s_dat_i[acc_g*MW +: MW];
                  end
               end
            end
            ISSUE: begin
               stb_r <= 1'b1;
               cnt_q <= '0;
               state <= WAIT;
            end
            WAIT: begin
               cnt_q <= cnt_q + 10'd1;
               if (hit && !hit_err) begin
                  cap_q  <= cap_nxt;
                  mask_q <= nmask;
                  stb_r  <= 1'b0;
                  if (nmask != '0) begin
                     g_q   <= ng;
                     adr_r <= beat_adr(adr_q, ng);
                     sel_r <= sel_q[ng*(MW/8) +: MW/8];
                     dat_r <= dat_q[ng*MW +: MW];
                     state <= ISSUE;
                  end else begin
                     cyc_r   <= 1'b0;
                     adr_r   <= '1;
                     sel_r   <= '0;
                     ack_r   <= 1'b1;
                     s_tid_r <= tid_q;
                     s_dat_r <= cap_nxt;
                     state   <= DONE;
                  end
               end else if (hit || timeout) begin
                  cyc_r   <= 1'b0;
                  stb_r   <= 1'b0;
                  adr_r   <= '1;
                  sel_r   <= '0;
                  err_r   <= 1'b1;
                  s_tid_r <= tid_q;
                  s_dat_r <= cap_q;
                  state   <= DONE;
               end
            end
            DONE: begin
               ack_r   <= 1'b0;
               err_r   <= 1'b0;
               stall_r <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.s_stall_o = stall_r;
   assign bus.s_ack_o   = ack_r;
   assign bus.s_err_o   = err_r;
   assign bus.s_tid_o   = s_tid_r;
   assign bus.s_dat_o   = s_dat_r;
   assign bus.m_cyc_o   = cyc_r;
   assign bus.m_stb_o   = stb_r;
   assign bus.m_we_o    = we_r;
   assign bus.m_sel_o   = sel_r;
   assign bus.m_adr_o   = adr_r;
   assign bus.m_dat_o   = dat_r;
   assign bus.m_tid_o   = tid_r;
endmodule

// File: tb/tb_io_bridge_fta_split.sv
// Directed bench for io_bridge_fta_split: split beats, merge, channel
// priority, error and timeout termination, empty request and reset.
module tb_io_bridge_fta_split;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   io_bridge_fta_split_if #(
      .SW(128), .MW(64), .CHANNELS(4), .ADRW(32)
   ) bus ();

   io_bridge_fta_split #(
      .SW(128), .MW(64), .CHANNELS(4), .ADRW(32), .TIMEOUT(1023)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic we, input logic [15:0] sel,
                      input logic [31:0] adr, input logic [127:0] dat,
                      input logic [7:0] tid);
      bus.s_cyc_i = 1'b1;
      bus.s_we_i  = we;
      bus.s_sel_i = sel;
      bus.s_adr_i = adr;
      bus.s_dat_i = dat;
      bus.s_tid_i = tid;
      step();
      bus.s_cyc_i = 1'b0;
   endtask

   task automatic rsp(input logic [3:0] ack, input logic [3:0] err,
                      input logic [31:0] tids, input logic [255:0] dat);
      bus.ch_ack_i = ack;
      bus.ch_err_i = err;
      bus.ch_tid_i = tids;
      bus.ch_dat_i = dat;
   endtask

   initial begin
      bus.s_cyc_i = 1'b0;
      bus.s_we_i  = 1'b0;
      bus.s_sel_i = '0;
      bus.s_adr_i = '0;
      bus.s_dat_i = '0;
      bus.s_tid_i = '0;
      rsp(4'h0, 4'h0, 32'h0, 256'h0);
      step();
      step();
      chk("rst_adr", bus.m_adr_o, 32'hFFFF_FFFF);
      chk("rst_cyc", bus.m_cyc_o, 1'b0);
      chk("rst_stall", bus.s_stall_o, 1'b0);
      chk("rst_ack", bus.s_ack_o, 1'b0);
      rst = 1'b0;
      step();

      // single-beat read, ch1 acks in first WAIT cycle
      req(1'b0, 16'h00F0, 32'hFFD0_0010, 128'h0, 8'h05);
      chk("r1_stb", bus.m_stb_o, 1'b1);
      chk("r1_cyc", bus.m_cyc_o, 1'b1);
      chk("r1_adr", bus.m_adr_o, 32'hFFD0_0010);
      chk("r1_sel", bus.m_sel_o, 8'hF0);
      chk("r1_stall", bus.s_stall_o, 1'b1);
      step();
      rsp(4'b0010, 4'h0, 32'h0000_0500, {128'h0, 64'h1122_3344_5566_7788, 64'h0});
      step();
      rsp(4'h0, 4'h0, 32'h0, 256'h0);
      chk("r1_ack", bus.s_ack_o, 1'b1);
      chk("r1_err", bus.s_err_o, 1'b0);
      chk("r1_dat", bus.s_dat_o, {64'h0, 64'h1122_3344_5566_7788});
      chk("r1_tid", bus.s_tid_o, 8'h05);
      chk("r1_done_cyc", bus.m_cyc_o, 1'b0);
      chk("r1_done_adr", bus.m_adr_o, 32'hFFFF_FFFF);
      step();
      chk("r1_ack_pulse", bus.s_ack_o, 1'b0);
      chk("r1_stall_drop", bus.s_stall_o, 1'b0);
      chk("r1_dat_hold", bus.s_dat_o, {64'h0, 64'h1122_3344_5566_7788});

      // two-beat write
      req(1'b1, 16'h0FF0, 32'h0000_0100,
          {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB}, 8'h07);
      chk("w_b0_adr", bus.m_adr_o, 32'h0000_0100);
      chk("w_b0_sel", bus.m_sel_o, 8'hF0);
      chk("w_b0_dat", bus.m_dat_o, 64'hBBBB_BBBB_BBBB_BBBB);
      chk("w_b0_we", bus.m_we_o, 1'b1);
      step();
      rsp(4'b0001, 4'h0, 32'h0000_0007, 256'h0);
      step();
      rsp(4'h0, 4'h0, 32'h0, 256'h0);
      chk("w_gap_stb", bus.m_stb_o, 1'b0);
      chk("w_gap_cyc", bus.m_cyc_o, 1'b1);
      chk("w_b1_adr", bus.m_adr_o, 32'h0000_0108);
      chk("w_b1_sel", bus.m_sel_o, 8'h0F);
      chk("w_b1_dat", bus.m_dat_o, 64'hAAAA_AAAA_AAAA_AAAA);
      chk("w_b1_ack_early", bus.s_ack_o, 1'b0);
      step();
      chk("w_b1_stb", bus.m_stb_o, 1'b1);
      rsp(4'b0001, 4'h0, 32'h0000_0007, 256'h0);
      step();
      rsp(4'h0, 4'h0, 32'h0, 256'h0);
      chk("w_ack", bus.s_ack_o, 1'b1);
      chk("w_dat_zero", bus.s_dat_o, 128'h0);
      step();
      chk("w_ack_pulse", bus.s_ack_o, 1'b0);

      // upper-group read, ch0 and ch2 collide
      req(1'b0, 16'hFF00, 32'h0000_0200, 128'h0, 8'h09);
      chk("p_adr", bus.m_adr_o, 32'h0000_0208);
      chk("p_sel", bus.m_sel_o, 8'hFF);
      step();
      rsp(4'b0101, 4'h0, 32'h0009_0009,
          {64'h0, 64'h2, 64'h0, 64'h1});
      step();
      rsp(4'h0, 4'h0, 32'h0, 256'h0);
      chk("p_ack", bus.s_ack_o, 1'b1);
      chk("p_dat", bus.s_dat_o, {64'h1, 64'h0});
      step();
      chk("p_once_ack", bus.s_ack_o, 1'b0);
      chk("p_once_err", bus.s_err_o, 1'b0);

      // error on first beat of a full-width read
      req(1'b0, 16'hFFFF, 32'h0000_0300, 128'h0, 8'h03);
      chk("e_adr", bus.m_adr_o, 32'h0000_0300);
      step();
      rsp(4'h0, 4'b1000, 32'h0300_0000, 256'h0);
      step();
      rsp(4'h0, 4'h0, 32'h0, 256'h0);
      chk("e_err", bus.s_err_o, 1'b1);
      chk("e_noack", bus.s_ack_o, 1'b0);
      chk("e_cyc", bus.m_cyc_o, 1'b0);
      step();
      chk("e_err_pulse", bus.s_err_o, 1'b0);
      chk("e_no_beat1", bus.m_stb_o, 1'b0);

      // timeout with a wrong-tid ack on the way
      req(1'b0, 16'h000F, 32'h0000_0400, 128'h0, 8'h11);
      step();
      rsp(4'b0001, 4'h0, 32'h0000_0012, 256'h0);
      step();
      rsp(4'h0, 4'h0, 32'h0, 256'h0);
      chk("t_ignore_ack", bus.s_ack_o, 1'b0);
      for (int i = 0; i < 1021; i++) step();
      chk("t_pre_err", bus.s_err_o, 1'b0);
      chk("t_pre_cyc", bus.m_cyc_o, 1'b1);
      step();
      chk("t_err", bus.s_err_o, 1'b1);
      chk("t_cyc", bus.m_cyc_o, 1'b0);
      chk("t_noack", bus.s_ack_o, 1'b0);
      step();

      // empty select
      req(1'b0, 16'h0000, 32'h0000_0600, 128'h0, 8'h22);
      chk("z_ack", bus.s_ack_o, 1'b1);
      chk("z_cyc", bus.m_cyc_o, 1'b0);
      chk("z_tid", bus.s_tid_o, 8'h22);
      chk("z_dat", bus.s_dat_o, 128'h0);
      step();
      chk("z_ack_pulse", bus.s_ack_o, 1'b0);

      // reset in WAIT, then a late ack
      req(1'b0, 16'h00FF, 32'h0000_0500, 128'h0, 8'h33);
      step();
      chk("x_wait_cyc", bus.m_cyc_o, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("x_adr", bus.m_adr_o, 32'hFFFF_FFFF);
      chk("x_cyc", bus.m_cyc_o, 1'b0);
      chk("x_stb", bus.m_stb_o, 1'b0);
      chk("x_sel", bus.m_sel_o, 8'h00);
      chk("x_stall", bus.s_stall_o, 1'b0);
      chk("x_tid", bus.s_tid_o, 8'h00);
      rsp(4'b0001, 4'h0, 32'h0000_0033, {192'h0, 64'hDEAD});
      step();
      rsp(4'h0, 4'h0, 32'h0, 256'h0);
      chk("x_late_ack", bus.s_ack_o, 1'b0);
      chk("x_late_dat", bus.s_dat_o, 128'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
